// File: rtl/udma_cfg_apb_bridge.sv
// udma_cfg_apb_bridge
// APB slave that turns each APB transfer into exactly one uDMA cfg-bus
// transaction and returns the response to the APB master.
// Optional responder timeout: define UDMA_CFG_BRIDGE_TIMEOUT_EN to enable.
module udma_cfg_apb_bridge #(
  parameter int unsigned APB_AWIDTH     = 12,
  parameter int unsigned CFG_AWIDTH     = 5,
  parameter int unsigned WINDOW_WORDS   = 20,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [APB_AWIDTH-1:0] paddr_i,
  input  logic [31:0]           pwdata_i,
  input  logic                  pwrite_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [CFG_AWIDTH-1:0] cfg_addr_o,
  output logic [31:0]           cfg_data_o,
  output logic                  cfg_valid_o,
  output logic                  cfg_rwn_o,
  input  logic [31:0]           cfg_data_i,
  input  logic                  cfg_ready_i
);

  // Elaboration-time parameter sanity checks
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end
  if (APB_AWIDTH < CFG_AWIDTH + 3) begin : g_bad_awidth
    $error("APB_AWIDTH must exceed CFG_AWIDTH+2");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [CFG_AWIDTH-1:0] cfg_addr_q;
  logic [31:0]           cfg_data_q;
  logic                  cfg_rwn_q;
  logic [31:0]           prdata_q;
  logic                  err_q;

  logic                  setup;
  logic                  accept;
  logic [CFG_AWIDTH-1:0] idx;
  logic [APB_AWIDTH-1:0] hi_bits;
  logic                  setup_err;
  logic                  cfg_done;
  logic                  tmo_hit;

  assign setup     = psel_i & ~penable_i;
  assign accept    = (state_q == IDLE) & setup;
  assign idx       = paddr_i[CFG_AWIDTH+1:2];
  assign hi_bits   = paddr_i >> (CFG_AWIDTH + 2);
  assign setup_err = (|paddr_i[1:0]) | (|hi_bits) | (32'(idx) >= WINDOW_WORDS);
  assign cfg_done  = (state_q == ISSUE) & cfg_ready_i;

`ifdef UDMA_CFG_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_q;

  // The counter holds (ISSUE cycles elapsed - 1), so comparing against
  // TIMEOUT_CYCLES-1 fires in the TIMEOUT_CYCLES-th ISSUE cycle; a ready
  // in that same cycle takes priority.
  assign tmo_hit = (state_q == ISSUE) & ~cfg_ready_i & (tmo_cnt_q == TMO_LAST);

  // Wait counter: cleared when a transfer enters ISSUE, counts stalled cycles
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_cnt_q <= '0;
    end else if (accept && !setup_err) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ISSUE) && !cfg_ready_i) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = setup_err ? RESP : ISSUE;
      ISSUE:   if (cfg_done || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; pready only while the master is still in its access phase
  always_comb begin
    cfg_valid_o = 1'b0;
    pready_o    = 1'b0;
    pslverr_o   = 1'b0;
    case (state_q)
      ISSUE: cfg_valid_o = 1'b1;
      RESP: begin
        pready_o  = psel_i & penable_i;
        pslverr_o = psel_i & penable_i & err_q;
      end
      default: ;
    endcase
  end

  // Request/response datapath: latch request on setup, capture read data on completion
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      cfg_rwn_q  <= 1'b1;
      prdata_q   <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      cfg_addr_q <= idx;
      cfg_data_q <= pwrite_i ? pwdata_i : '0;
      cfg_rwn_q  <= ~pwrite_i;
      prdata_q   <= '0;
      err_q      <= setup_err;
    end else if (cfg_done) begin
      prdata_q   <= cfg_rwn_q ? cfg_data_i : '0;
      err_q      <= 1'b0;
    end else if (tmo_hit) begin
      prdata_q   <= 32'hDEAD_BEEF;
      err_q      <= 1'b1;
    end
  end

  assign cfg_addr_o = cfg_addr_q;
  assign cfg_data_o = cfg_data_q;
  assign cfg_rwn_o  = cfg_rwn_q;
  assign prdata_o   = prdata_q;

endmodule

// File: tb/tb_udma_cfg_apb_bridge.sv
// Testbench for udma_cfg_apb_bridge: table-driven APB transfers plus
// hand-written corner sequences; cfg transactions checked via a scoreboard.
module tb_udma_cfg_apb_bridge;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i;
  logic        pwrite_i;
  logic        psel_i;
  logic        penable_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_i;

  always #5 clk_i = ~clk_i;

  udma_cfg_apb_bridge #(
    .APB_AWIDTH    (12),
    .CFG_AWIDTH    (5),
    .WINDOW_WORDS  (20),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .paddr_i    (paddr_i),
    .pwdata_i   (pwdata_i),
    .pwrite_i   (pwrite_i),
    .psel_i     (psel_i),
    .penable_i  (penable_i),
    .prdata_o   (prdata_o),
    .pready_o   (pready_o),
    .pslverr_o  (pslverr_o),
    .cfg_addr_o (cfg_addr_o),
    .cfg_data_o (cfg_data_o),
    .cfg_valid_o(cfg_valid_o),
    .cfg_rwn_o  (cfg_rwn_o),
    .cfg_data_i (cfg_data_i),
    .cfg_ready_i(cfg_ready_i)
  );

  typedef struct {
    logic [4:0]  addr;
    logic        rwn;
    logic [31:0] data;
  } cfg_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int unsigned dly;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_cyc;
    int unsigned exp_vcyc;
  } vec_t;

  cfg_t        exp_q[$];
  cfg_t        obs_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned rsp_delay = 0;
  int unsigned wait_cnt = 0;
  int unsigned vcyc = 0;
  int unsigned cyc = 0;

  // Responder read data: a fixed pattern per index, index 16 returns 0x15
  function automatic logic [31:0] resp_data(input logic [4:0] a);
    return (a == 5'd16) ? 32'h0000_0015 : (32'hC0DE_0000 | 32'(a));
  endfunction

  always @(posedge clk_i) cyc++;

  // cfg responder + monitor: ready after rsp_delay valid cycles, record handshakes
  always @(negedge clk_i) begin
    if (cfg_valid_o) begin
      vcyc++;
      if (wait_cnt >= rsp_delay) begin
        cfg_ready_i = 1'b1;
        cfg_data_i  = resp_data(cfg_addr_o);
        obs_q.push_back('{cfg_addr_o, cfg_rwn_o, cfg_data_o});
      end else begin
        cfg_ready_i = 1'b0;
        cfg_data_i  = 32'hBAD0_0000 | 32'(wait_cnt);
        wait_cnt++;
      end
    end else begin
      cfg_ready_i = 1'b0;
      cfg_data_i  = '0;
      wait_cnt    = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic [11:0] addr, input logic [31:0] wdata, input logic wr,
                          output logic [31:0] rdata, output logic err, output int unsigned ncyc);
    int unsigned n;
    @(negedge clk_i);
    paddr_i = addr; pwdata_i = wdata; pwrite_i = wr; psel_i = 1'b1; penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1;
    n = 1;
    while (!pready_o && n < 300) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    rdata = prdata_o;
    err   = pslverr_o;
    ncyc  = n;
    if (!pready_o) begin
      checks++;
      errors++;
      $display("FAIL apb_pready_timeout: got no pready after %0d cycles, required pready", n);
      ncyc = 0;
    end
  endtask

  task automatic apb_idle();
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic sb_drain(input string tag);
    cfg_t o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_cfg_extra: got addr 0x%02h rwn %0d data 0x%08h, required none",
                 tag, o.addr, o.rwn, o.data);
      end else begin
        e = exp_q.pop_front();
        if (o.addr !== e.addr || o.rwn !== e.rwn || o.data !== e.data) begin
          errors++;
          $display("FAIL %s_cfg_txn: got addr 0x%02h rwn %0d data 0x%08h, required addr 0x%02h rwn %0d data 0x%08h",
                   tag, o.addr, o.rwn, o.data, e.addr, e.rwn, e.data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_cfg_missing: got 0 transactions, required %0d", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] rd;
    logic        er;
    int unsigned n, v0, t0, saw;

    vecs[0] = '{12'h02C, 32'h0000_1234, 1'b1, 0, 32'h0000_0000, 1'b0, 2, 1};
    vecs[1] = '{12'h000, 32'h0,         1'b0, 0, 32'hC0DE_0000, 1'b0, 2, 1};
    vecs[2] = '{12'h040, 32'h0,         1'b0, 3, 32'h0000_0015, 1'b0, 5, 4};
    vecs[3] = '{12'h050, 32'h0,         1'b0, 0, 32'h0000_0000, 1'b1, 1, 0};
    vecs[4] = '{12'h006, 32'h0,         1'b0, 0, 32'h0000_0000, 1'b1, 1, 0};
    vecs[5] = '{12'h04C, 32'hFFFF_FFFF, 1'b1, 1, 32'h0000_0000, 1'b0, 3, 2};
    vecs[6] = '{12'h04C, 32'h0,         1'b0, 0, 32'hC0DE_0013, 1'b0, 2, 1};
    vecs[7] = '{12'h080, 32'h0000_5555, 1'b1, 0, 32'h0000_0000, 1'b1, 1, 0};
    vecs[8] = '{12'h803, 32'h0000_5555, 1'b1, 0, 32'h0000_0000, 1'b1, 1, 0};
    vecs[9] = '{12'h010, 32'h0,         1'b0, 2, 32'hC0DE_0004, 1'b0, 4, 3};

    rstn_i = 1'b0; paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_prdata",  prdata_o, 32'h0);
    chk("rst_pready",  32'(pready_o), 32'h0);
    chk("rst_pslverr", 32'(pslverr_o), 32'h0);
    chk("rst_valid",   32'(cfg_valid_o), 32'h0);
    chk("rst_addr",    32'(cfg_addr_o), 32'h0);
    chk("rst_data",    cfg_data_o, 32'h0);
    chk("rst_rwn",     32'(cfg_rwn_o), 32'h1);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Table-driven single transfers
    for (int i = 0; i < 10; i++) begin
      rsp_delay = vecs[i].dly;
      v0 = vcyc;
      if (vecs[i].exp_vcyc != 0)
        exp_q.push_back('{vecs[i].addr[6:2], !vecs[i].wr, vecs[i].wr ? vecs[i].wdata : 32'h0});
      apb_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wr, rd, er, n);
      apb_idle();
      sb_drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_cycles", i), n, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_valid_cycles", i), vcyc - v0, vecs[i].exp_vcyc);
    end

    // Reset asserted while the bridge waits in ISSUE
    rsp_delay = 1000;
    @(negedge clk_i);
    paddr_i = 12'h008; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rstmid_valid_before", 32'(cfg_valid_o), 32'h1);
    @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("rstmid_valid", 32'(cfg_valid_o), 32'h0);
    chk("rstmid_pready", 32'(pready_o), 32'h0);
    chk("rstmid_rwn", 32'(cfg_rwn_o), 32'h1);
    chk("rstmid_addr", 32'(cfg_addr_o), 32'h0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    saw = 0;
    repeat (6) begin
      @(negedge clk_i);
      #1;
      if (pready_o || cfg_valid_o) saw = 1;
    end
    chk("rstmid_no_pready_after", saw, 0);
    apb_idle();
    sb_drain("rstmid");
    rsp_delay = 0;
    exp_q.push_back('{5'd2, 1'b1, 32'h0});
    apb_xfer(12'h008, 32'h0, 1'b0, rd, er, n);
    apb_idle();
    sb_drain("rstmid_after");
    chk("rstmid_after_prdata", rd, 32'hC0DE_0002);
    chk("rstmid_after_cycles", n, 2);

    // psel dropped during ISSUE: cfg write still completes, no pready
    rsp_delay = 3;
    v0 = vcyc;
    exp_q.push_back('{5'd3, 1'b0, 32'h0000_A5A5});
    @(negedge clk_i);
    paddr_i = 12'h00C; pwdata_i = 32'h0000_A5A5; pwrite_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
    saw = 0;
    repeat (8) begin
      @(negedge clk_i);
      #1;
      if (pready_o) saw = 1;
    end
    chk("abandon_no_pready", saw, 0);
    chk("abandon_valid_cycles", vcyc - v0, 4);
    sb_drain("abandon");
    rsp_delay = 0;
    exp_q.push_back('{5'd3, 1'b1, 32'h0});
    apb_xfer(12'h00C, 32'h0, 1'b0, rd, er, n);
    apb_idle();
    sb_drain("abandon_after");
    chk("abandon_after_prdata", rd, 32'hC0DE_0003);
    chk("abandon_after_cycles", n, 2);

    // Ten back-to-back reads at one transfer per three cycles
    rsp_delay = 0;
    v0 = vcyc;
    @(negedge clk_i);
    t0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{5'(i), 1'b1, 32'h0});
      apb_xfer(12'(i * 4), 32'h0, 1'b0, rd, er, n);
      chk($sformatf("b2b%0d_prdata", i), rd, 32'hC0DE_0000 | 32'(i));
    end
    chk("b2b_total_cycles", cyc - t0 + 1, 30);
    apb_idle();
    chk("b2b_valid_cycles", vcyc - v0, 10);
    sb_drain("b2b");

`ifdef UDMA_CFG_BRIDGE_TIMEOUT_EN
    // Responder never answers: timeout after 8 valid cycles
    rsp_delay = 1000;
    v0 = vcyc;
    apb_xfer(12'h014, 32'h0, 1'b0, rd, er, n);
    apb_idle();
    sb_drain("tmo");
    chk("tmo_prdata", rd, 32'hDEAD_BEEF);
    chk("tmo_pslverr", 32'(er), 32'h1);
    chk("tmo_cycles", n, 9);
    chk("tmo_valid_cycles", vcyc - v0, 8);
    // Ready on the limiting cycle wins
    rsp_delay = 7;
    v0 = vcyc;
    exp_q.push_back('{5'd5, 1'b1, 32'h0});
    apb_xfer(12'h014, 32'h0, 1'b0, rd, er, n);
    apb_idle();
    sb_drain("tmo_edge");
    chk("tmo_edge_prdata", rd, 32'hC0DE_0005);
    chk("tmo_edge_pslverr", 32'(er), 32'h0);
    chk("tmo_edge_cycles", n, 9);
    chk("tmo_edge_valid_cycles", vcyc - v0, 8);
`endif

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udma_cfg_apb_bridge.md
Name: udma_cfg_apb_bridge

Overview:
- APB-slave to uDMA cfg-bus initiator. It drives the cfg_valid/cfg_rwn/cfg_addr/cfg_data request side of a peripheral register interface, such as the Ethernet config block, and returns the response to the APB master.
- Converts one APB transfer into exactly one cfg transaction and waits for cfg_ready_i.
- Flags APB errors for out-of-window addresses, misaligned addresses, and (optionally) responder timeouts.
- Sits between the SoC APB interconnect and one uDMA peripheral cfg port.

Parameters:
APB_AWIDTH, 12, APB address width.
CFG_AWIDTH, 5, cfg register index width (word index).
WINDOW_WORDS, 20, number of implemented cfg words; indices at or above this value are errors.
TIMEOUT_CYCLES, 64, cfg wait limit, used only with the optional feature; range 2..255.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
paddr_i  in  APB_AWIDTH  APB byte address
pwdata_i  in  32  APB write data
pwrite_i  in  1  1 = write
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
cfg_addr_o  out  CFG_AWIDTH  register index = paddr_i[CFG_AWIDTH+1:2]
cfg_data_o  out  32  write data
cfg_valid_o  out  1  request valid
cfg_rwn_o  out  1  1 = read, 0 = write
cfg_data_i  in  32  responder read data
cfg_ready_i  in  1  responder accept/complete

Behaviour:
- Reset (asynchronous, rstn_i low):
  - State IDLE.
  - All outputs 0: prdata_o, pready_o, pslverr_o, cfg_valid_o, cfg_addr_o, cfg_data_o; cfg_rwn_o = 1.
  - Timeout counter 0.
  - Reset mid-transaction aborts it silently; no pready is generated afterwards.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Wait for the setup phase: psel_i=1 and penable_i=0.
  - On setup, latch address index, pwdata_i and ~pwrite_i into registers.
  - Error check:
    - paddr_i[1:0] != 0 → error.
    - paddr_i[APB_AWIDTH-1:CFG_AWIDTH+2] != 0 → error.
    - index >= WINDOW_WORDS → error.
  - Error → go to RESP with err=1; no cfg transaction is issued.
  - No error → go to ISSUE.
- ISSUE:
  - cfg_valid_o=1 with stable addr/data/rwn until cfg_ready_i=1 is sampled.
  - Read data: in the cycle cfg_ready_i=1, register cfg_data_i into prdata_o. For writes, prdata_o=0.
  - cfg_data_o=0 during reads.
  - Next cycle: cfg_valid_o=0, go to RESP with err=0.
- RESP:
  - pready_o=1 and pslverr_o=err for exactly one cycle, but only if psel_i & penable_i.
  - If psel_i=0, the transfer was abandoned (APB protocol violation): return to IDLE with no pready.
  - Otherwise go to IDLE.
  - prdata_o holds until the next transaction latches.
- Latency, with cfg_ready_i tied to 1:
  - setup T0, cfg_valid T1, pready T2.
  - One APB wait state; back-to-back transfers sustain one transfer per 3 cycles.
  - Each extra cfg wait cycle adds one APB wait state.
- Exactly one cfg_valid pulse sequence per APB transfer.
  - A read never issues twice; this matters because ERROR registers clear on read.
- psel_i dropping during ISSUE: the cfg transaction still completes, then the block returns to IDLE with no pready.
- A new setup phase is accepted only in IDLE.
- pslverr_o is never asserted without pready_o.

Optional Feature:
- Macro: UDMA_CFG_BRIDGE_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entering ISSUE and increments every ISSUE cycle without cfg_ready_i.
  - When the count reaches TIMEOUT_CYCLES: drop cfg_valid_o, set prdata_o=32'hDEAD_BEEF, go to RESP with err=1.
  - A cfg_ready_i arriving in the same cycle as the limit wins: normal completion, err=0.
- Not defined: no counter logic; ISSUE waits indefinitely for cfg_ready_i.

Test Plan:
- Write paddr=0x02C, pwdata=0x0000_1234, ready tied 1 → exactly one cfg_valid cycle with addr=5'h0B, rwn=0, data=0x1234; pready at T2; pslverr=0.
- Read paddr=0x040, responder returns 0x0000_0015 with ready delayed 3 cycles → cfg_valid high for 4 cycles (until ready sampled), single ready; prdata=0x15 at pready, which is 3 cycles later than the no-wait case.
- Read paddr=0x050 (index 20) and paddr=0x006 (misaligned) → no cfg_valid; pready+pslverr one cycle after setup; prdata=0.
- Timeout build, TIMEOUT_CYCLES=8, ready held 0 → cfg_valid for 8 cycles then low; pslverr=1; prdata=0xDEADBEEF. Second run with ready asserted on the 8th cycle → normal completion, pslverr=0.
- rstn_i asserted during ISSUE → cfg_valid_o, pready_o 0 immediately; next transfer after release completes normally.
- Back-to-back 10 reads, ready tied 1 → 10 cfg_valid pulses, 30 cycles total, no duplicated read.
